// File: rtl/pll_lock_divider_pkg.sv
// Shared TX PHY definitions: lock FSM state encoding and default PLL/serializer ratios.
package pll_lock_divider_pkg;

  localparam int PLL_RATIO_DEF = 50;
  localparam int SYM_W_DEF     = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } pll_state_e;

endpackage

// File: rtl/pll_lock_divider_word_clk_div.sv
// Serializer word clock: integer divide of the PLL clock, running only while enabled.
module pll_lock_divider_word_clk_div
  import pll_lock_divider_pkg::*;
#(
  parameter int DIV = SYM_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  output logic o_word_clk,
  output logic o_word_strobe
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] HALF = DW'(DIV / 2);

  logic [DW-1:0] r_div_cnt;
  logic          r_word_clk;
  logic          r_word_strobe;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_div_cnt     <= '0;
      r_word_clk    <= 1'b0;
      r_word_strobe <= 1'b0;
    end else begin
      r_div_cnt     <= (r_div_cnt == LAST) ? '0 : r_div_cnt + DW'(1);
      r_word_clk    <= (r_div_cnt < HALF);
      r_word_strobe <= (r_div_cnt == LAST);
    end
  end

  // Gating with the enable drops the outputs in the very cycle lock is lost.
  assign o_word_clk    = r_word_clk & i_en;
  assign o_word_strobe = r_word_strobe & i_en;

endmodule

// File: rtl/pll_lock_divider.sv
// PLL lock detector: measures CLK cycles per Ref_Clk period and, once locked, drives the word clock.
//   state      | meaning
//   ST_IDLE    | waiting for the first reference edge after reset
//   ST_MEASURE | counting consecutive in-tolerance periods
//   ST_LOCKED  | lock declared, word clock divider running
module pll_lock_divider
  import pll_lock_divider_pkg::*;
#(
  parameter int EXP_RATIO = PLL_RATIO_DEF,
  parameter int TOL       = 2,
  parameter int LOCK_CNT  = 4,
  parameter int DIV       = SYM_W_DEF,
  parameter int CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Ref_Clk,
  output logic             Locked,
  output logic             Lock_Lost,
  output logic [CNT_W-1:0] Meas_Period,
  output logic             Word_Clk,
  output logic             Word_Strobe
);

  localparam logic [CNT_W-1:0] SAT     = CNT_W'(2 * EXP_RATIO);
  localparam logic [CNT_W-1:0] PRE_SAT = CNT_W'(2 * EXP_RATIO - 1);
  localparam logic [CNT_W-1:0] LO      = CNT_W'(EXP_RATIO - TOL);
  localparam logic [CNT_W-1:0] HI      = CNT_W'(EXP_RATIO + TOL);
  localparam int               GW      = $clog2(LOCK_CNT + 1);
  localparam logic [GW-1:0]    GOOD_LAST = GW'(LOCK_CNT - 1);

  logic             r_sync1, r_sync2, r_sync3;
  logic [CNT_W-1:0] r_period_cnt;
  logic [CNT_W-1:0] r_meas_period;
  logic [GW-1:0]    r_good_cnt;
  pll_state_e       r_state;
  logic             r_locked;
  logic             r_lock_lost;

  logic w_ref_rise, w_in_tol, w_good, w_timeout, w_bad;

  assign w_ref_rise = r_sync2 & ~r_sync3;
  assign w_in_tol   = (r_period_cnt >= LO) && (r_period_cnt <= HI);
  assign w_good     = w_ref_rise & w_in_tol;
  // Fires only on the step into saturation, so a dead reference yields one bad event.
  assign w_timeout  = ~w_ref_rise & (r_period_cnt == PRE_SAT);
  assign w_bad      = (w_ref_rise & ~w_in_tol) | w_timeout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1       <= 1'b0;
      r_sync2       <= 1'b0;
      r_sync3       <= 1'b0;
      r_period_cnt  <= '0;
      r_meas_period <= '0;
    end else begin
      r_sync1 <= Ref_Clk;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      if (w_ref_rise) begin
        r_period_cnt <= CNT_W'(1);
        if (r_state != ST_IDLE) r_meas_period <= r_period_cnt;
      end else if (r_period_cnt != SAT) begin
        r_period_cnt <= r_period_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_good_cnt  <= '0;
      r_locked    <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_lock_lost <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ref_rise) begin
            r_state    <= ST_MEASURE;
            r_good_cnt <= '0;
          end
        end
        ST_MEASURE: begin
          if (w_bad) begin
            r_good_cnt <= '0;
          end else if (w_good) begin
            if (r_good_cnt == GOOD_LAST) begin
              r_state    <= ST_LOCKED;
              r_locked   <= 1'b1;
              r_good_cnt <= '0;
            end else begin
              r_good_cnt <= r_good_cnt + GW'(1);
            end
          end
        end
        ST_LOCKED: begin
          if (w_bad) begin
            r_state     <= ST_MEASURE;
            r_good_cnt  <= '0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b1;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  pll_lock_divider_word_clk_div #(
    .DIV(DIV)
  ) u_word_clk_div (
    .i_clk        (CLK),
    .i_rst        (RST),
    .i_en         (r_locked),
    .o_word_clk   (Word_Clk),
    .o_word_strobe(Word_Strobe)
  );

  assign Locked      = r_locked;
  assign Lock_Lost   = r_lock_lost;
  assign Meas_Period = r_meas_period;

endmodule

// File: doc/pll_lock_divider.md
Name: pll_lock_divider

Overview:
- Sits directly downstream of the TX PHY PLL frequency multiplier and consumes its fast output clock CLK.
- Samples the PLL reference clock Ref_Clk as data and measures the CLK-cycles-per-reference-period ratio.
- Declares PLL lock after a run of in-tolerance periods.
- Once locked, generates the serializer word clock and a load strobe by integer division of CLK.

Parameters:
- EXP_RATIO, 50, expected CLK cycles per Ref_Clk period (PLL multiply factor).
- TOL, 2, allowed deviation in cycles; absorbs synchronizer jitter.
- LOCK_CNT, 4, consecutive good periods required to declare lock.
- DIV, 10, word clock divide ratio (10-bit symbol serializer); must be ≥2.
- CNT_W, 8, period counter width; must hold 2*EXP_RATIO.

Ports:
- CLK  in  1  fast PLL output clock; the only clock.
- RST  in  1  synchronous, active-high reset.
- Ref_Clk  in  1  reference clock, treated as an asynchronous data input.
- Locked  out  1  PLL lock indication.
- Lock_Lost  out  1  one-cycle pulse when Locked falls.
- Meas_Period  out  CNT_W  last measured period, in CLK cycles.
- Word_Clk  out  1  divided clock: high for DIV/2 cycles (floor), low for the remainder.
- Word_Strobe  out  1  one-cycle pulse on the last CLK cycle of each word.

Behaviour:
- Reset values: Locked=0, Lock_Lost=0, Meas_Period=0, Word_Clk=0, Word_Strobe=0. All internal counters and synchronizer flops are 0; state is IDLE.
- Synchronizer: r1←Ref_Clk, r2←r1, r3←r2. ref_rise = r2 & ~r3. Detection latency is 2–3 CLK cycles after the Ref_Clk edge.
- Period counter:
  - On ref_rise: Meas_Period←period_cnt, then period_cnt←1.
  - Otherwise period_cnt increments, saturating at 2*EXP_RATIO.
- good = ref_rise and |period_cnt − EXP_RATIO| ≤ TOL.
- bad = (ref_rise and not good) or (period_cnt reaches 2*EXP_RATIO; a timeout fires once per saturation).
- State machine:
  - IDLE: wait for the first ref_rise (no measurement is taken on it) → MEASURE, good_cnt=0.
  - MEASURE:
    - good → good_cnt+1.
    - bad → good_cnt=0, stay in MEASURE.
    - When good_cnt would reach LOCK_CNT → LOCKED, and Locked=1 on the next cycle.
  - LOCKED:
    - bad → MEASURE, good_cnt=0, Locked=0, Lock_Lost=1 for one cycle.
    - good → stay in LOCKED.
- Timeout in IDLE (Ref_Clk absent): remain in IDLE; Meas_Period is not updated.
- Divider:
  - div_cnt is held at 0 and Word_Clk/Word_Strobe are held at 0 while not LOCKED.
  - In the cycle Locked rises, div_cnt starts at 0. It then counts 0..DIV−1 and wraps.
  - Word_Clk = (div_cnt < DIV/2), registered.
  - Word_Strobe = (div_cnt == DIV−1), registered.
  - First Word_Clk high appears in the cycle after Locked rises.
- Loss of lock stops the divider in the same cycle Locked falls. Word_Clk returns to 0 even if mid-high (a truncated pulse is acceptable).
- Simultaneous ref_rise and saturation: ref_rise wins; the measurement uses the saturated value and counts as bad.
- RST asserted mid-operation: every output and state returns to reset values on the next CLK edge. No Lock_Lost pulse is generated by reset.

Decomposition:
- Shared PHY package holds:
  - the state enum (IDLE, MEASURE, LOCKED);
  - default constants: PLL ratio 50, symbol width 10.
- One natural sub-module: word_clk_div. It holds the divider counter, Word_Clk and Word_Strobe, with an enable input driven by Locked.
- The synchronizer and lock FSM stay in the top module.

Test Plan:
- Ref period exactly 50 CLK, RST released:
  - Locked=0 through the first 4 measured periods.
  - Locked=1 one cycle after the 5th ref_rise.
  - Meas_Period=50.
- After lock with DIV=10: Word_Clk pattern is 5 high / 5 low; Word_Strobe pulses every 10 cycles, aligned to the last low cycle.
- While locked, inject one ref period of 55 CLK:
  - Lock_Lost pulses once.
  - Locked=0 and Word_Clk=0 that cycle.
  - Relock after 4 further 50-cycle periods.
- Ref periods alternating 48/52 (within TOL=2): lock is achieved and held; Meas_Period tracks 48/52.
- Stop Ref_Clk while locked:
  - After period_cnt hits 100, Locked falls with a single Lock_Lost pulse.
  - No further pulses while Ref_Clk stays stopped.
- Assert RST for 1 cycle mid-word while locked: all outputs are 0 the next cycle, and the full relock sequence is required again.
